// File: rtl/ctrl_issue_unit.sv
// Registered ID/EX issue control: decodes mode/opcode/S/cond into EXE/MEM/WB
// controls, evaluates ARM conditions, and waits on memory with a timeout.
module ctrl_issue_unit #(
   parameter int CMD_W       = 4,
   parameter int TO_W        = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [1:0]       mode,
   input  logic [3:0]       opcode,
   input  logic             s_bit,
   input  logic [3:0]       cond,
   input  logic [3:0]       nzcv,
   input  logic             stall,
   input  logic             flush,
   input  logic             mem_ready,
   output logic             out_valid,
   output logic [CMD_W-1:0] exe_cmd,
   output logic             mem_read,
   output logic             mem_write,
   output logic             wb_en,
   output logic             branch,
   output logic             status_update,
   output logic             busy,
   output logic             mem_err
);

   typedef enum logic {ISSUE, MEM_WAIT} state_t;

   state_t          state, state_nxt;
   logic [TO_W-1:0] cnt, cnt_nxt;
   logic            accept, load_dec, load_bub, set_err;
   logic            dec_ok, dec_vld, dec_rd, dec_wr, dec_wb, dec_br, dec_su;
   logic [3:0]      dec_cmd;

   function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      {n, z, cf, v} = f;
      case (c)
         4'b0000: return z;
         4'b0001: return !z;
         4'b0010: return cf;
         4'b0011: return !cf;
         4'b0100: return n;
         4'b0101: return !n;
         4'b0110: return v;
         4'b0111: return !v;
         4'b1000: return cf && !z;
         4'b1001: return !cf || z;
         4'b1010: return n == v;
         4'b1011: return n != v;
         4'b1100: return !z && (n == v);
         4'b1101: return z || (n != v);
         4'b1110: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   assign busy   = (state == MEM_WAIT) && !mem_ready;
   assign accept = in_valid && !stall && !busy && !flush;

   // Decode: anything unsupported or condition-failed collapses to a bubble.
   always_comb begin
      dec_ok  = 1'b0;
      dec_cmd = 4'd0;
      dec_rd  = 1'b0;
      dec_wr  = 1'b0;
      dec_wb  = 1'b0;
      dec_br  = 1'b0;
      dec_su  = 1'b0;
      case (mode)
         2'b00: begin
            dec_ok = 1'b1;
            dec_wb = 1'b1;
            dec_su = s_bit;
            case (opcode)
               4'b1101: dec_cmd = 4'b0001;
               4'b1111: dec_cmd = 4'b1001;
               4'b0100: dec_cmd = 4'b0010;
               4'b0101: dec_cmd = 4'b0011;
               4'b0010: dec_cmd = 4'b0100;
               4'b0110: dec_cmd = 4'b0101;
               4'b0000: dec_cmd = 4'b0110;
               4'b1100: dec_cmd = 4'b0111;
               4'b0001: dec_cmd = 4'b1000;
               4'b1010: begin dec_cmd = 4'b0100; dec_wb = 1'b0; dec_su = 1'b1; end
               4'b1000: begin dec_cmd = 4'b0110; dec_wb = 1'b0; dec_su = 1'b1; end
               default: dec_ok = 1'b0;
            endcase
         end
         2'b01: begin
            dec_ok  = 1'b1;
            dec_cmd = 4'b0010;
            dec_rd  = s_bit;
            dec_wr  = !s_bit;
            dec_wb  = s_bit;
         end
         2'b10: begin
            dec_ok = 1'b1;
            dec_br = 1'b1;
         end
         default: dec_ok = 1'b0;
      endcase
      dec_vld = dec_ok && in_valid && cond_pass(cond, nzcv);
      if (!dec_vld) begin
         dec_cmd = 4'd0;
         dec_rd  = 1'b0;
         dec_wr  = 1'b0;
         dec_wb  = 1'b0;
         dec_br  = 1'b0;
         dec_su  = 1'b0;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      load_dec  = 1'b0;
      load_bub  = 1'b0;
      set_err   = 1'b0;
      case (state)
         ISSUE: begin
            if (flush) begin
               load_bub = 1'b1;
            end else if (!stall) begin
               if (accept) begin
                  load_dec = 1'b1;
                  if (dec_rd || dec_wr) begin
                     state_nxt = MEM_WAIT;
                     cnt_nxt   = '0;
                  end
               end else begin
                  load_bub = 1'b1;
               end
            end
         end
         MEM_WAIT: begin
            if (flush) begin
               load_bub  = 1'b1;
               state_nxt = ISSUE;
            end else if (mem_ready) begin
               state_nxt = ISSUE;
               if (accept) begin
                  load_dec = 1'b1;
                  if (dec_rd || dec_wr) begin
                     state_nxt = MEM_WAIT;
                     cnt_nxt   = '0;
                  end
               end else begin
                  load_bub = 1'b1;
               end
            end else if (cnt == TO_W'(MEM_TIMEOUT - 1)) begin
               set_err   = 1'b1;
               load_bub  = 1'b1;
               state_nxt = ISSUE;
            end else begin
               cnt_nxt = cnt + TO_W'(1);
            end
         end
         default: state_nxt = ISSUE;
      endcase
   end

   // ID/EX boundary register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ISSUE;
         cnt           <= '0;
         out_valid     <= 1'b0;
         exe_cmd       <= '0;
         mem_read      <= 1'b0;
         mem_write     <= 1'b0;
         wb_en         <= 1'b0;
         branch        <= 1'b0;
         status_update <= 1'b0;
         mem_err       <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (set_err) mem_err <= 1'b1;
         if (load_dec || load_bub) begin
            out_valid     <= load_dec && dec_vld;
            exe_cmd       <= load_dec ? CMD_W'(dec_cmd) : '0;
            mem_read      <= load_dec && dec_rd;
            mem_write     <= load_dec && dec_wr;
            wb_en         <= load_dec && dec_wb;
            branch        <= load_dec && dec_br;
            status_update <= load_dec && dec_su;
         end
      end
   end

endmodule

// File: tb/tb_ctrl_issue_unit.sv
// Scoreboard bench for ctrl_issue_unit: stimulus queues expected post-edge
// snapshots; a monitor pops and compares one after every rising edge.
module tb_ctrl_issue_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, s_bit, stall, flush, mem_ready;
   logic [1:0] mode;
   logic [3:0] opcode, cond, nzcv;
   logic       out_valid, mem_read, mem_write, wb_en, branch, status_update, busy, mem_err;
   logic [3:0] exe_cmd;

   typedef struct packed {
      logic       ov;
      logic [3:0] cmd;
      logic       rd, wr, wb, br, su, bsy, err;
   } exp_t;

   exp_t  q[$];
   string nq[$];
   int    checks = 0;
   int    errors = 0;

   ctrl_issue_unit dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .opcode(opcode),
      .s_bit(s_bit), .cond(cond), .nzcv(nzcv), .stall(stall), .flush(flush),
      .mem_ready(mem_ready), .out_valid(out_valid), .exe_cmd(exe_cmd),
      .mem_read(mem_read), .mem_write(mem_write), .wb_en(wb_en), .branch(branch),
      .status_update(status_update), .busy(busy), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   function automatic exp_t ex(input logic ov, input logic [3:0] cmd, input logic rd,
                               input logic wr, input logic wb, input logic br,
                               input logic su, input logic bsy, input logic err);
      exp_t e;
      e = '{ov, cmd, rd, wr, wb, br, su, bsy, err};
      return e;
   endfunction

   function automatic exp_t sample();
      return ex(out_valid, exe_cmd, mem_read, mem_write, wb_en, branch,
                status_update, busy, mem_err);
   endfunction

   task automatic chk(input string name, input exp_t act, input exp_t want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, want);
      end
   endtask

   task automatic set_in(input logic iv, input logic [1:0] m, input logic [3:0] op,
                         input logic s, input logic [3:0] c, input logic [3:0] f,
                         input logic st, input logic fl, input logic mr);
      in_valid = iv; mode = m; opcode = op; s_bit = s; cond = c; nzcv = f;
      stall = st; flush = fl; mem_ready = mr;
   endtask

   task automatic step(input string name, input exp_t e);
      q.push_back(e);
      nq.push_back(name);
      @(posedge clk);
      @(negedge clk);
   endtask

   always @(posedge clk) begin
      #1;
      if (q.size() > 0) chk(nq.pop_front(), sample(), q.pop_front());
   end

   initial begin
      rst_n = 1'b0;
      set_in(0, 2'b00, 4'h0, 0, 4'hE, 4'h0, 0, 0, 0);
      @(negedge clk);
      step("reset", ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
      rst_n = 1'b1;

      set_in(1, 2'b00, 4'b0100, 0, 4'hE, 4'h0, 0, 0, 0);
      step("add", ex(1, 4'b0010, 0, 0, 1, 0, 0, 0, 0));
      set_in(1, 2'b00, 4'b0100, 1, 4'hE, 4'h0, 0, 0, 0);
      step("adds", ex(1, 4'b0010, 0, 0, 1, 0, 1, 0, 0));
      set_in(1, 2'b00, 4'b1010, 0, 4'hE, 4'h0, 0, 0, 0);
      step("cmp", ex(1, 4'b0100, 0, 0, 0, 0, 1, 0, 0));
      set_in(1, 2'b00, 4'b1000, 0, 4'hE, 4'h0, 0, 0, 0);
      step("tst", ex(1, 4'b0110, 0, 0, 0, 0, 1, 0, 0));
      set_in(1, 2'b00, 4'b1111, 0, 4'hE, 4'h0, 0, 0, 0);
      step("mvn", ex(1, 4'b1001, 0, 0, 1, 0, 0, 0, 0));
      set_in(1, 2'b00, 4'b0011, 1, 4'hE, 4'h0, 0, 0, 0);
      step("bad_op", ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
      set_in(1, 2'b10, 4'h0, 0, 4'b0000, 4'b0000, 0, 0, 0);
      step("eq_fail", ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
      set_in(1, 2'b10, 4'h0, 0, 4'b0000, 4'b0100, 0, 0, 0);
      step("eq_pass", ex(1, 0, 0, 0, 0, 1, 0, 0, 0));
      set_in(1, 2'b10, 4'h0, 0, 4'b1100, 4'b1001, 0, 0, 0);
      step("gt_pass", ex(1, 0, 0, 0, 0, 1, 0, 0, 0));
      set_in(1, 2'b10, 4'h0, 0, 4'b1011, 4'b1001, 0, 0, 0);
      step("lt_fail", ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
      set_in(1, 2'b00, 4'b0100, 0, 4'b1111, 4'h0, 0, 0, 0);
      step("never", ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
      set_in(0, 2'b00, 4'b0100, 0, 4'hE, 4'h0, 0, 0, 0);
      step("idle", ex(0, 0, 0, 0, 0, 0, 0, 0, 0));

      // LDR waits 3 cycles, then mem_ready admits the queued MOV
      set_in(1, 2'b01, 4'h0, 1, 4'hE, 4'h0, 0, 0, 0);
      step("ldr", ex(1, 4'b0010, 1, 0, 1, 0, 0, 1, 0));
      set_in(1, 2'b00, 4'b1101, 0, 4'hE, 4'h0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step("ldr_wait", ex(1, 4'b0010, 1, 0, 1, 0, 0, 1, 0));
      set_in(1, 2'b00, 4'b1101, 0, 4'hE, 4'h0, 0, 0, 1);
      step("mov_after_ldr", ex(1, 4'b0001, 0, 0, 1, 0, 0, 0, 0));

      // STR with no ack times out on the 15th wait cycle
      set_in(1, 2'b01, 4'h0, 0, 4'hE, 4'h0, 0, 0, 0);
      step("str", ex(1, 4'b0010, 0, 1, 0, 0, 0, 1, 0));
      set_in(0, 2'b00, 4'h0, 0, 4'hE, 4'h0, 0, 0, 0);
      for (int i = 0; i < 14; i++) step("str_wait", ex(1, 4'b0010, 0, 1, 0, 0, 0, 1, 0));
      step("timeout", ex(0, 0, 0, 0, 0, 0, 0, 0, 1));
      step("err_sticky", ex(0, 0, 0, 0, 0, 0, 0, 0, 1));

      set_in(1, 2'b00, 4'b1100, 0, 4'hE, 4'h0, 0, 0, 0);
      step("orr", ex(1, 4'b0111, 0, 0, 1, 0, 0, 0, 1));
      set_in(1, 2'b00, 4'b0001, 0, 4'hE, 4'h0, 1, 0, 0);
      step("stall_hold", ex(1, 4'b0111, 0, 0, 1, 0, 0, 0, 1));
      step("stall_hold2", ex(1, 4'b0111, 0, 0, 1, 0, 0, 0, 1));
      set_in(1, 2'b00, 4'b0001, 0, 4'hE, 4'h0, 1, 1, 0);
      step("flush_stall", ex(0, 0, 0, 0, 0, 0, 0, 0, 1));

      set_in(1, 2'b01, 4'h0, 1, 4'hE, 4'h0, 0, 0, 0);
      step("ldr2", ex(1, 4'b0010, 1, 0, 1, 0, 0, 1, 1));
      set_in(0, 2'b00, 4'h0, 0, 4'hE, 4'h0, 0, 1, 0);
      step("flush_wait", ex(0, 0, 0, 0, 0, 0, 0, 0, 1));

      // asynchronous reset in the middle of an LDR wait
      set_in(1, 2'b01, 4'h0, 1, 4'hE, 4'h0, 0, 0, 0);
      step("ldr3", ex(1, 4'b0010, 1, 0, 1, 0, 0, 1, 1));
      set_in(0, 2'b00, 4'h0, 0, 4'hE, 4'h0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1 chk("async_rst", sample(), ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;

      // mem_ready arriving exactly at the timeout cycle wins
      set_in(1, 2'b01, 4'h0, 0, 4'hE, 4'h0, 0, 0, 0);
      step("str2", ex(1, 4'b0010, 0, 1, 0, 0, 0, 1, 0));
      set_in(0, 2'b00, 4'h0, 0, 4'hE, 4'h0, 0, 0, 0);
      for (int i = 0; i < 14; i++) step("str2_wait", ex(1, 4'b0010, 0, 1, 0, 0, 0, 1, 0));
      set_in(0, 2'b00, 4'h0, 0, 4'hE, 4'h0, 0, 0, 1);
      step("ready_at_to", ex(0, 0, 0, 0, 0, 0, 0, 0, 0));

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain got=%0d pending want=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
